// File: rtl/seq_array_multiplier.sv
// Sequential shift-and-add array multiplier: one partial-product row per cycle, valid/ready on both sides.
// Optional two's-complement mode is built in when SIGNED_MULT_EN is defined (adds the signed_mode port).
module seq_array_multiplier #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in1,
    input  logic [N-1:0]     in2,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SIGNED_MULT_EN
    input  logic             signed_mode,
`endif
    output logic [M+N-1:0]   product
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready=1 in IDLE, 0 in BUSY, out_ready in DONE; out_valid=1 only in DONE.
    localparam int W  = M + N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [M-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          sign_reg;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;

    logic          mode_in;
    logic          accept;
    logic [W-1:0]  a_ext;
    logic [W-1:0]  row;
    logic [W-1:0]  shifted;
    logic          subtract;
    logic [W-1:0]  acc_next;

`ifdef SIGNED_MULT_EN
    assign mode_in = signed_mode;
`else
    assign mode_in = 1'b0;
`endif

    assign in_ready  = rst || (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = !rst && (state == DONE);
    assign product   = acc;
    assign accept    = in_valid && in_ready;

    // In signed mode the multiplier's top bit carries negative weight, so its row is subtracted.
    always_comb begin
        a_ext    = sign_reg ? {{N{a_reg[M-1]}}, a_reg} : {{N{1'b0}}, a_reg};
        row      = b_reg[cnt] ? a_ext : '0;
        shifted  = row << cnt;
        subtract = sign_reg && (cnt == LAST);
        acc_next = subtract ? (acc - shifted) : (acc + shifted);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sign_reg <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg    <= in1;
                        b_reg    <= in2;
                        sign_reg <= mode_in;
                        cnt      <= '0;
                        acc      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            a_reg    <= in1;
                            b_reg    <= in2;
                            sign_reg <= mode_in;
                            cnt      <= '0;
                            acc      <= '0;
                            state    <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier (M=N=4); signed vectors run when SIGNED_MULT_EN is defined.
module tb_seq_array_multiplier;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
`ifdef SIGNED_MULT_EN
    logic       signed_mode;
`endif

    int total = 0;
    int bad   = 0;

    seq_array_multiplier #(.M(4), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SIGNED_MULT_EN
        .signed_mode (signed_mode),
`endif
        .product   (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to a bounded number of edges for out_valid; returns edges elapsed.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    // Offer operands from IDLE, check latency and product, then drain to IDLE.
    task automatic run_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic smode, input logic [7:0] exp);
        int cycles;
`ifdef SIGNED_MULT_EN
        signed_mode = smode;
`endif
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in1 = ~a;
        in2 = ~b;
        check({tag, "_busy_ready"}, in_ready, 1'b0);
        wait_done(cycles);
        check({tag, "_latency"}, cycles, 4);
        check({tag, "_product"}, product, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 1'b0);
        check({tag, "_idle_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        int cycles;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in1 = '0;
        in2 = '0;
`ifdef SIGNED_MULT_EN
        signed_mode = 1'b0;
`endif
        tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        check("rst_product", product, 8'h00);
        tick();
        check("post_rst_ready", in_ready, 1'b1);
        check("post_rst_valid", out_valid, 1'b0);

        run_mult("m13x11", 4'd13, 4'd11, 1'b0, 8'h8F);
        run_mult("m15x15", 4'd15, 4'd15, 1'b0, 8'hE1);
        run_mult("m0x9",   4'd0,  4'd9,  1'b0, 8'h00);
        run_mult("m8x8",   4'd8,  4'd8,  1'b0, 8'h40);

        // Stall in DONE with a new request pending, then release into back-to-back accept.
        in1 = 4'd9;
        in2 = 4'd10;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(cycles);
        check("stall_latency", cycles, 4);
        in1 = 4'd3;
        in2 = 4'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_product", product, 8'h5A);
            check("stall_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        in1 = 4'd15;
        in2 = 4'd15;
        check("b2b_valid", out_valid, 1'b0);
        check("b2b_busy", in_ready, 1'b0);
        wait_done(cycles);
        check("b2b_latency", cycles, 4);
        check("b2b_product", product, 8'h0F);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of a 7*7 operation.
        in1 = 4'd7;
        in2 = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_ready_during", in_ready, 1'b1);
        check("midrst_valid_during", out_valid, 1'b0);
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        check("midrst_product", product, 8'h00);
        for (int i = 0; i < 6; i++) tick();
        check("midrst_no_result", out_valid, 1'b0);
        run_mult("m2x3", 4'd2, 4'd3, 1'b0, 8'h06);

`ifdef SIGNED_MULT_EN
        run_mult("s_m8xm8", 4'h8, 4'h8, 1'b1, 8'h40);
        run_mult("s_m8x7",  4'h8, 4'h7, 1'b1, 8'hC8);
        run_mult("s_m1xm1", 4'hF, 4'hF, 1'b1, 8'h01);
        run_mult("u_8x8",   4'h8, 4'h8, 1'b0, 8'h40);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_array_multiplier.md
SEQ_ARRAY_MULTIPLIER -- requirements
Module: seq_array_multiplier

Interface
REQ-001 SHALL have parameter M, default 4: in1 width in bits, M >= 2.
REQ-002 SHALL have parameter N, default 4: in2 width in bits, N >= 2; equals the number of partial-product rows and the iteration count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  block can accept operands this cycle.
REQ-007 SHALL have port in1  input  M  multiplicand.
REQ-008 SHALL have port in2  input  N  multiplier.
REQ-009 SHALL have port out_valid  output  1  product is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the product.
REQ-011 SHALL have port product  output  M+N  result.

Function
REQ-012 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-014 SHALL, on an IDLE edge with in_valid=1, capture in1/in2 into internal registers, clear the accumulator, set row counter=0 and enter BUSY.
REQ-015 SHALL, on each BUSY edge, add ((in1_reg AND replicate(in2_reg[cnt])) << cnt) to the (M+N)-bit accumulator and increment cnt.
REQ-016 SHALL take exactly one adder row per cycle, giving an M-bit ripple row plus carry into the accumulator.
REQ-017 SHALL transition BUSY->DONE on the edge that processes cnt=N-1; out_valid rises N cycles after the accept edge.
REQ-018 SHALL, in DONE, drive out_valid=1 and hold product=accumulator stable until the handshake completes.
REQ-019 SHALL drive in_ready=0 in BUSY and in_ready=out_ready in DONE.
REQ-020 SHALL, on a DONE edge with out_ready=1 and in_valid=0, enter IDLE.
REQ-021 SHALL, on a DONE edge with out_ready=1 and in_valid=1, capture the new operands and enter BUSY directly (back-to-back, N+1 cycles per result).
REQ-022 SHALL, on a DONE edge with out_ready=0, remain in DONE and ignore in_valid.
REQ-023 SHALL ignore in1/in2 changes after capture.
REQ-024 SHALL produce the exact M+N-bit product; no overflow is possible.

Reset
REQ-025 SHALL, on an rst=1 edge in any state, including mid-BUSY, enter IDLE, clear the accumulator/product to 0 and cnt to 0, and discard the in-flight operation.
REQ-026 SHALL hold out_valid=0 and in_ready=1 during and after reset.

Configuration
REQ-027 SHALL, when macro SIGNED_MULT_EN is defined, add input port signed_mode (1 bit), sampled with the operands.
REQ-028 SHALL, with SIGNED_MULT_EN defined and signed_mode=1, treat in1/in2 as two's complement: in1 is sign-extended to M+N bits, and row N-1 is subtracted instead of added.
REQ-029 SHALL, without SIGNED_MULT_EN, omit the signed_mode port and always multiply unsigned, with behaviour identical to signed_mode=0.

Verification (M=N=4)
REQ-030 SHALL cover: in1=13, in2=11, in_valid=1 in IDLE -> out_valid exactly 4 cycles after accept, product=0x8F.
REQ-031 SHALL cover: in1=15, in2=15 -> product=0xE1; in1=0, in2=9 -> product=0x00.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles in DONE -> product stable, in_ready=0, new in_valid ignored; out_ready=1 with in_valid=1 (3*5) -> next product=0x0F with no IDLE cycle.
REQ-033 SHALL cover: rst=1 two cycles after accepting 7*7 -> next edge IDLE, out_valid=0, product=0; a following 2*3 -> product=0x06.
REQ-034 SHALL cover, with SIGNED_MULT_EN defined and signed_mode=1: -8*-8 -> 0x40, -8*7 -> 0xC8, -1*-1 -> 0x01; with signed_mode=0, 8*8 -> 0x40.
